// File: rtl/blink_monitor.sv
// blink_monitor: measures the spacing of led transitions against the blinker's
// half-period 2**CBITS, locks after LOCK_CNT in-window intervals, and latches
// a sticky error when a locked blink drifts out of window or stops.
module blink_monitor #(
  parameter int CBITS    = 9,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             led,
  output logic             locked,
  output logic             err,
  output logic             edge_det,
  output logic [CBITS+1:0] period
);

  // Two spare bits keep HALF+TOL+1 and the saturated count free of overflow.
  localparam int W  = CBITS + 2;
  localparam int GW = $clog2(LOCK_CNT + 1);

  localparam logic [W-1:0] HALF = W'(1) << CBITS;
  localparam logic [W-1:0] LO   = HALF - W'(TOL);
  localparam logic [W-1:0] HI   = HALF + W'(TOL);
  localparam logic [W-1:0] TMO  = HI + W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SYNC   = 2'd1,
    S_LOCKED = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [GW-1:0]  good;
  logic [GW-1:0]  good_nxt;
  logic           led_q;
  logic           vld;
  logic [W-1:0]   ival;
  logic           tgl;
  logic           in_win;
  logic           timeout;

  // An edge needs one prior sample, so the first sample after reset is silent.
  assign tgl     = vld && (led != led_q);
  assign in_win  = (ival >= LO) && (ival <= HI);
  // An edge landing on the timeout cycle is judged as an out-of-window edge.
  assign timeout = !tgl && (ival == TMO);

  // Previous led sample and detector arming.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld   <= 1'b0;
      led_q <= 1'b0;
    end else begin
      vld   <= 1'b1;
      led_q <= led;
    end
  end

  // Interval counter: restarts at 1 on each edge, holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      ival <= '0;
    end else if (tgl) begin
      ival <= W'(1);
    end else if (ival != '1) begin
      ival <= ival + W'(1);
    end
  end

  // Lock/verify decision for the current cycle.
  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    case (state)
      S_IDLE: begin
        if (tgl) begin
          state_nxt = S_SYNC;
          good_nxt  = '0;
        end
      end
      S_SYNC: begin
        if (tgl) begin
          if (in_win) begin
            good_nxt = good + GW'(1);
            if (good + GW'(1) == GW'(LOCK_CNT)) begin
              state_nxt = S_LOCKED;
            end
          end else begin
            good_nxt = '0;
          end
        end else if (timeout) begin
          good_nxt = '0;
        end
      end
      S_LOCKED: begin
        if ((tgl && !in_win) || timeout) begin
          state_nxt = S_ERR;
        end
      end
      S_ERR: begin
        state_nxt = S_ERR;
      end
      default: begin
        state_nxt = S_IDLE;
        good_nxt  = '0;
      end
    endcase
  end

  // State register and registered outputs, all decided from this cycle's sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      good     <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
      edge_det <= 1'b0;
      period   <= '0;
    end else begin
      state    <= state_nxt;
      good     <= good_nxt;
      locked   <= (state_nxt == S_LOCKED);
      err      <= (state_nxt == S_ERR);
      edge_det <= tgl;
      if (tgl && (state != S_IDLE)) begin
        period <= ival;
      end
    end
  end

endmodule

// File: tb/tb_blink_monitor.sv
// tb_blink_monitor: two monitors (TOL=0 and TOL=1, CBITS=4, LOCK_CNT=2) watch the
// same led line; a timestamp-based reference model predicts every output.
module tb_blink_monitor;

  localparam int CB   = 4;
  localparam int HALF = 16;
  localparam int SAT  = 63;
  localparam int LOCK = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       led = 1'b0;
  logic       locked_a, err_a, edge_a;
  logic       locked_b, err_b, edge_b;
  logic [5:0] period_a, period_b;

  blink_monitor #(.CBITS(CB), .TOL(0), .LOCK_CNT(LOCK)) dut_a (
    .clk(clk), .rst(rst), .led(led),
    .locked(locked_a), .err(err_a), .edge_det(edge_a), .period(period_a)
  );

  blink_monitor #(.CBITS(CB), .TOL(1), .LOCK_CNT(LOCK)) dut_b (
    .clk(clk), .rst(rst), .led(led),
    .locked(locked_b), .err(err_b), .edge_det(edge_b), .period(period_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: time of the last edge plus per-monitor lock bookkeeping.
  int now = 0;
  bit m_armed;
  bit m_prev;
  int m_last;
  bit m_edge;
  bit m_seen[2];
  int m_streak[2];
  bit m_lock[2];
  bit m_err[2];
  int m_period[2];
  int tolv[2] = '{0, 1};

  task automatic step(input bit l, input bit r);
    int gap;
    bit e;
    bit inwin;
    bit tmo;
    led = l;
    rst = r;
    @(posedge clk);
    now++;
    if (r) begin
      m_armed = 1'b0;
      m_last  = now + 1;
      m_edge  = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_seen[i] = 0; m_streak[i] = 0; m_lock[i] = 0; m_err[i] = 0; m_period[i] = 0;
      end
    end else begin
      e   = m_armed && (l != m_prev);
      gap = now - m_last;
      if (gap > SAT) gap = SAT;
      m_edge = e;
      for (int i = 0; i < 2; i++) begin
        inwin = (gap >= HALF - tolv[i]) && (gap <= HALF + tolv[i]);
        tmo   = !e && (gap == HALF + tolv[i] + 1);
        if (e && m_seen[i]) m_period[i] = gap;
        if (!m_seen[i]) begin
          if (e) begin
            m_seen[i]   = 1'b1;
            m_streak[i] = 0;
          end
        end else if (m_err[i]) begin
          m_err[i] = 1'b1;
        end else if (m_lock[i]) begin
          if ((e && !inwin) || tmo) begin
            m_lock[i] = 1'b0;
            m_err[i]  = 1'b1;
          end
        end else if (e) begin
          if (inwin) begin
            m_streak[i]++;
            if (m_streak[i] == LOCK) m_lock[i] = 1'b1;
          end else begin
            m_streak[i] = 0;
          end
        end else if (tmo) begin
          m_streak[i] = 0;
        end
      end
      if (e) m_last = now;
      m_armed = 1'b1;
      m_prev  = l;
    end
    #1;
  endtask

  function automatic logic [17:0] obs();
    return {locked_a, err_a, edge_a, period_a, locked_b, err_b, edge_b, period_b};
  endfunction

  function automatic logic [17:0] expv();
    return {m_lock[0], m_err[0], m_edge, 6'(m_period[0]),
            m_lock[1], m_err[1], m_edge, 6'(m_period[1])};
  endfunction

  task automatic test_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    n_cmp++;
    if (obs() !== 18'd0) begin
      n_bad++; $display("FAIL reset_state got=%h want=%h", obs(), 18'd0);
    end
    step(1'b0, 1'b0);
    n_cmp++;
    if (obs() !== expv()) begin
      n_bad++; $display("FAIL reset_rearm got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_nominal();
    int iv[$] = '{5, 16, 16};
    step(led, 1'b1);
    foreach (iv[j]) for (int k = 1; k <= iv[j]; k++) begin
      step((k == iv[j]) ? ~led : led, 1'b0);
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL nominal t=%0d got=%h want=%h", now, obs(), expv());
      end
    end
    n_cmp++;
    if ({locked_a, err_a, edge_a, period_a} !== {1'b1, 1'b0, 1'b1, 6'd16}) begin
      n_bad++; $display("FAIL nominal_lock got=%b/%b/%b/%0d want=1/0/1/16", locked_a, err_a, edge_a, period_a);
    end
    for (int k = 1; k <= 32; k++) begin
      step((k % 16 == 0) ? ~led : led, 1'b0);
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL nominal_hold t=%0d got=%h want=%h", now, obs(), expv());
      end
    end
    n_cmp++;
    if ({locked_a, err_a, locked_b, err_b} !== 4'b1010) begin
      n_bad++; $display("FAIL nominal_stay got=%b want=1010", {locked_a, err_a, locked_b, err_b});
    end
  endtask

  task automatic test_tolerance();
    int iv[$] = '{3, 16, 16, 15, 17};
    int iv2[$] = '{3, 16, 16, 14};
    step(led, 1'b1);
    foreach (iv[j]) for (int k = 1; k <= iv[j]; k++) begin
      step((k == iv[j]) ? ~led : led, 1'b0);
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL tol_edges t=%0d got=%h want=%h", now, obs(), expv());
      end
    end
    n_cmp++;
    if ({locked_b, err_b, err_a} !== 3'b101) begin
      n_bad++; $display("FAIL tol_15_17 got=%b want=101", {locked_b, err_b, err_a});
    end
    for (int k = 1; k <= 18; k++) begin
      step(led, 1'b0);
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL tol_18 t=%0d got=%h want=%h", now, obs(), expv());
      end
    end
    n_cmp++;
    if ({locked_b, err_b} !== 2'b01) begin
      n_bad++; $display("FAIL tol_timeout got=%b want=01", {locked_b, err_b});
    end
    step(led, 1'b1);
    foreach (iv2[j]) for (int k = 1; k <= iv2[j]; k++) begin
      step((k == iv2[j]) ? ~led : led, 1'b0);
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL tol_14 t=%0d got=%h want=%h", now, obs(), expv());
      end
    end
    n_cmp++;
    if ({locked_b, err_b, edge_b} !== 3'b011) begin
      n_bad++; $display("FAIL tol_short got=%b want=011", {locked_b, err_b, edge_b});
    end
  endtask

  task automatic test_stuck();
    int iv[$] = '{3, 16, 16};
    int ka = -1;
    int kb = -1;
    step(led, 1'b1);
    foreach (iv[j]) for (int k = 1; k <= iv[j]; k++) begin
      step((k == iv[j]) ? ~led : led, 1'b0);
    end
    for (int k = 1; k <= 30; k++) begin
      step(led, 1'b0);
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL stuck t=%0d got=%h want=%h", now, obs(), expv());
      end
      if (err_a && ka < 0) ka = k;
      if (err_b && kb < 0) kb = k;
    end
    n_cmp++;
    if (ka != 17) begin
      n_bad++; $display("FAIL stuck_delay_a got=%0d want=17", ka);
    end
    n_cmp++;
    if (kb != 18) begin
      n_bad++; $display("FAIL stuck_delay_b got=%0d want=18", kb);
    end
    n_cmp++;
    if (period_a !== 6'd16) begin
      n_bad++; $display("FAIL stuck_period got=%0d want=16", period_a);
    end
  endtask

  task automatic test_sync_recovery();
    int iv[$] = '{3, 16, 9, 16};
    step(led, 1'b1);
    foreach (iv[j]) for (int k = 1; k <= iv[j]; k++) begin
      step((k == iv[j]) ? ~led : led, 1'b0);
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL sync t=%0d got=%h want=%h", now, obs(), expv());
      end
    end
    n_cmp++;
    if (locked_a !== 1'b0) begin
      n_bad++; $display("FAIL sync_early got=%b want=0", locked_a);
    end
    for (int k = 1; k <= 16; k++) step((k == 16) ? ~led : led, 1'b0);
    n_cmp++;
    if ({locked_a, err_a} !== 2'b10) begin
      n_bad++; $display("FAIL sync_lock got=%b want=10", {locked_a, err_a});
    end
  endtask

  task automatic test_reset_mid();
    int iv[$] = '{3, 16, 16};
    int iv2[$] = '{4, 16, 16};
    step(led, 1'b1);
    foreach (iv[j]) for (int k = 1; k <= iv[j]; k++) step((k == iv[j]) ? ~led : led, 1'b0);
    step(led, 1'b1);
    n_cmp++;
    if (obs() !== 18'd0) begin
      n_bad++; $display("FAIL midrst_clear got=%h want=%h", obs(), 18'd0);
    end
    foreach (iv2[j]) for (int k = 1; k <= iv2[j]; k++) begin
      step((k == iv2[j]) ? ~led : led, 1'b0);
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL midrst_relock t=%0d got=%h want=%h", now, obs(), expv());
      end
    end
    n_cmp++;
    if (locked_a !== 1'b1) begin
      n_bad++; $display("FAIL midrst_locked got=%b want=1", locked_a);
    end
  endtask

  task automatic test_saturation();
    int iv[$] = '{3, 101};
    step(led, 1'b1);
    foreach (iv[j]) for (int k = 1; k <= iv[j]; k++) begin
      step((k == iv[j]) ? ~led : led, 1'b0);
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL sat t=%0d got=%h want=%h", now, obs(), expv());
      end
    end
    n_cmp++;
    if ({locked_a, err_a, edge_a, period_a} !== {1'b0, 1'b0, 1'b1, 6'd63}) begin
      n_bad++; $display("FAIL sat_edge got=%b/%b/%b/%0d want=0/0/1/63", locked_a, err_a, edge_a, period_a);
    end
  endtask

  task automatic test_random();
    int n;
    for (int b = 0; b < 4; b++) begin
      step(led, 1'b1);
      for (int j = 0; j < 12; j++) begin
        n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 70) : $urandom_range(14, 18);
        for (int k = 1; k <= n; k++) begin
          step((k == n) ? ~led : led, 1'b0);
          n_cmp++;
          if (obs() !== expv()) begin
            n_bad++; $display("FAIL random t=%0d got=%h want=%h", now, obs(), expv());
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_tolerance();
    test_stuck();
    test_sync_recovery();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
